seq_det_10110: RTL and testbench

Serial sequence detector that watches a one-bit input stream for the pattern 1-0-1-1-0, MSB first. It is the receive-side counterpart of the 10110 sequence generator. The block samples one bit per qualified clock (sample strobe `en`, normally driven by the divided-clock tick). It reports each detection as a one-cycle pulse, keeps a saturating detection count, and drives a pulse-stretched LED.

---
 rtl/seq_det_10110.sv | 100 ++++++++++
 tb/tb_seq_det_10110.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_10110.sv
// Serial 1-0-1-1-0 detector: one-cycle match pulse, saturating detection count,
// and a retriggerable pulse-stretched LED. One bit is consumed per cycle with en=1.
module seq_det_10110 #(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8,
  parameter int STRETCH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] count,
  output logic             led,
  output logic [2:0]       state
);

  localparam int STR_W = $clog2(STRETCH + 1);
  localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // State code equals the length of the matched prefix of 10110.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_e;

  logic [2:0]       state_q, state_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [STR_W-1:0] stretch_q, stretch_d;
  logic             led_q, led_d;
  logic             hit;

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    case (state_q)
      IDLE:  if (en) state_d = din ? S1 : IDLE;
      S1:    if (en) state_d = din ? S1 : S10;
      S10:   if (en) state_d = din ? S101 : IDLE;
      S101:  if (en) state_d = din ? S1011 : S10;
      S1011: begin
        if (en) begin
          if (din) begin
            state_d = S1;
          end else begin
            hit     = 1'b1;
            state_d = (OVERLAP != 0) ? S10 : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    match_d = hit;

    // clr beats a coincident detection; the count never wraps.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (hit && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end

    stretch_d = stretch_q;
    if (hit) begin
      stretch_d = STR_LOAD;
    end else if (stretch_q != '0) begin
      stretch_d = stretch_q - STR_W'(1);
    end
    led_d = (stretch_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      match_q   <= 1'b0;
      count_q   <= '0;
      stretch_q <= '0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      match_q   <= match_d;
      count_q   <= count_d;
      stretch_q <= stretch_d;
      led_q     <= led_d;
    end
  end

  assign match = match_q;
  assign count = count_q;
  assign led   = led_q;
  assign state = state_q;

endmodule

// File: tb/tb_seq_det_10110.sv
// Bench for seq_det_10110: three parameterisations share one stimulus stream and are
// compared every cycle against a sliding-window model, plus directed literal checks.
module tb_seq_det_10110;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, din = 1'b0, clr = 1'b0;

  logic       a_match, a_led, b_match, b_led, c_match, c_led;
  logic [7:0] a_count;
  logic [1:0] b_count, c_count;
  logic [2:0] a_state, b_state, c_state;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;
  bit m_flush = 1'b0;
  int na, nb, nc;

  always #5 clk = ~clk;

  seq_det_10110 #(.OVERLAP(1), .CNT_W(8), .STRETCH(16)) dut_a (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .match(a_match), .count(a_count), .led(a_led), .state(a_state));
  seq_det_10110 #(.OVERLAP(0), .CNT_W(2), .STRETCH(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .match(b_match), .count(b_count), .led(b_led), .state(b_state));
  seq_det_10110 #(.OVERLAP(1), .CNT_W(2), .STRETCH(4)) dut_c (
    .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
    .match(c_match), .count(c_count), .led(c_led), .state(c_state));

  // Model: last five sampled bits plus how many are valid since the last restart.
  logic [4:0] m_hist [3];
  int         m_hlen [3];
  bit         m_match[3];
  int         m_count[3];
  int         m_str  [3];

  function automatic int cfg_ov(int i);
    return (i == 1) ? 0 : 1;
  endfunction
  function automatic int cfg_cmax(int i);
    return (i == 0) ? 255 : 3;
  endfunction
  function automatic int cfg_str(int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic bit det_f(logic [4:0] h, int l, logic b);
    return (l >= 4) && ({h[3:0], b} == 5'b10110);
  endfunction

  function automatic int nlen(int l, bit det, int ov);
    if (det && ov == 0) return 0;
    return (l >= 5) ? 5 : l + 1;
  endfunction

  // Longest suffix of the valid history that is a proper prefix of 10110.
  function automatic int prefix_len(logic [4:0] h, int l);
    int r = 0;
    for (int k = 1; k <= 4; k++)
      if (k <= l && ((int'(h) & ((1 << k) - 1)) == (22 >> (5 - k)))) r = k;
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_hist[i]  <= 5'd0;
        m_hlen[i]  <= 0;
        m_match[i] <= 1'b0;
        m_count[i] <= 0;
        m_str[i]   <= 0;
      end else begin
        if (en) begin
          m_hist[i] <= {m_hist[i][3:0], din};
          m_hlen[i] <= nlen(m_hlen[i], det_f(m_hist[i], m_hlen[i], din), cfg_ov(i));
        end
        if (m_flush && i == 0) m_hlen[i] <= 0;
        m_match[i] <= en && det_f(m_hist[i], m_hlen[i], din);
        if (clr)
          m_count[i] <= 0;
        else if (en && det_f(m_hist[i], m_hlen[i], din))
          m_count[i] <= (m_count[i] + 1 > cfg_cmax(i)) ? cfg_cmax(i) : m_count[i] + 1;
        if (en && det_f(m_hist[i], m_hlen[i], din))
          m_str[i] <= cfg_str(i);
        else
          m_str[i] <= (m_str[i] > 0) ? m_str[i] - 1 : 0;
      end
    end
  end

  task automatic chk(input int i, input logic m, input int cnt, input logic l, input int st);
    checks += 4;
    if (m !== m_match[i]) begin
      errors++;
      $display("FAIL match inst%0d t=%0t: got %0b expected %0b", i, $time, m, m_match[i]);
    end
    if (cnt != m_count[i]) begin
      errors++;
      $display("FAIL count inst%0d t=%0t: got %0d expected %0d", i, $time, cnt, m_count[i]);
    end
    if (l !== (m_str[i] != 0)) begin
      errors++;
      $display("FAIL led inst%0d t=%0t: got %0b expected %0b", i, $time, l, m_str[i] != 0);
    end
    if (st != prefix_len(m_hist[i], m_hlen[i])) begin
      errors++;
      $display("FAIL state inst%0d t=%0t: got %0d expected %0d", i, $time, st,
               prefix_len(m_hist[i], m_hlen[i]));
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk(0, a_match, int'(a_count), a_led, int'(a_state));
      chk(1, b_match, int'(b_count), b_led, int'(b_state));
      chk(2, c_match, int'(c_count), c_led, int'(c_state));
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic r, input logic e, input logic d, input logic c);
    rst = r; en = e; din = d; clr = c;
    @(negedge clk); #1;
    if (a_match) na++;
    if (b_match) nb++;
    if (c_match) nc++;
  endtask

  task automatic frame(input logic clr_last);
    logic [4:0] pat = 5'b10110;
    for (int k = 4; k >= 0; k--) step(1'b0, 1'b1, pat[k], (k == 0) ? clr_last : 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    na = 0; nb = 0; nc = 0;
  endtask

  int sexp[5] = '{1, 2, 3, 4, 2};
  int cexp[5] = '{1, 2, 3, 3, 3};
  logic [7:0] stream8 = 8'b10110110;
  logic [4:0] pat5 = 5'b10110;
  int leds, st, run;
  bit done;

  initial begin
    @(negedge clk); #1;
    do_reset();
    do_reset();
    chk_on = 1'b1;
    lit("reset_state", int'(a_state), 0);
    lit("reset_count", int'(a_count), 0);
    lit("reset_led", int'(a_led), 0);
    lit("reset_match", int'(a_match), 0);

    // Single frame: state walk, pulse, count, 16-cycle LED
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, pat5[4-k], 1'b0);
      lit($sformatf("walk_state%0d", k), int'(a_state), sexp[k]);
      lit($sformatf("walk_match%0d", k), int'(a_match), (k == 4) ? 1 : 0);
    end
    lit("frame_count", int'(a_count), 1);
    leds = int'(a_led);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      leds += int'(a_led);
    end
    lit("led_high_cycles", leds, 16);

    // Overlap vs restart on 10110110
    do_reset();
    for (int k = 7; k >= 0; k--) step(1'b0, 1'b1, stream8[k], 1'b0);
    lit("ovl_pulses", na, 2);
    lit("ovl_count", int'(a_count), 2);
    lit("novl_pulses", nb, 1);
    lit("novl_count", int'(b_count), 1);

    // Sparse en with garbage between samples
    do_reset();
    for (int k = 4; k >= 0; k--) begin
      step(1'b0, 1'b1, pat5[k], 1'b0);
      st = int'(a_state);
      step(1'b0, 1'b0, 1'($urandom), 1'b0);
      step(1'b0, 1'b0, 1'($urandom), 1'b0);
      if (k == 2 || k == 1) lit($sformatf("hold_state_k%0d", k), int'(a_state), st);
    end
    lit("sparse_pulses", na, 1);

    // Saturation on the 2-bit counter, then clr against a detection
    do_reset();
    for (int f = 0; f < 5; f++) begin
      frame(1'b0);
      lit($sformatf("sat_count_f%0d", f), int'(b_count), cexp[f]);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    lit("sat_pulses", nb, 5);
    frame(1'b1);
    lit("clr_wins_count", int'(b_count), 0);
    lit("clr_wins_match", int'(b_match), 1);
    lit("clr_wins_led", int'(b_led), 1);

    // Reset discards a partial prefix
    do_reset();
    for (int k = 4; k >= 1; k--) step(1'b0, 1'b1, pat5[k], 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    lit("midrst_state", int'(a_state), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    lit("midrst_match", na, 0);
    lit("midrst_count", int'(a_count), 0);
    lit("midrst_led", int'(a_led), 0);

    // Retrigger: STRETCH=4, second detection three samples later
    do_reset();
    run = 0; done = 1'b0;
    for (int k = 0; k < 18; k++) begin
      if (k < 8) step(1'b0, 1'b1, stream8[7-k], 1'b0);
      else       step(1'b0, 1'b0, 1'b0, 1'b0);
      if (nc > 0 && !done) begin
        if (c_led) run++;
        else done = 1'b1;
      end
    end
    lit("retrig_pulses", nc, 2);
    lit("retrig_led_run", run, 7);

    // Illegal state code returns to IDLE on the next edge
    do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    en = 1'b0;
    force dut_a.state_q = 3'd6;
    #1 release dut_a.state_q;
    m_flush = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    m_flush = 1'b0;
    lit("illegal_to_idle", int'(a_state), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
